// File: rtl/display_mux_driver_pkg.sv
// Shared definitions for the multiplexed 7-segment display path:
// segment bit order, hex decode table and scan FSM encoding.
package display_mux_driver_pkg;

   typedef enum int {
      SEG_A = 0,
      SEG_B = 1,
      SEG_C = 2,
      SEG_D = 3,
      SEG_E = 4,
      SEG_F = 5,
      SEG_G = 6
   } seg_bit_e;

   localparam int SEG_W = int'(SEG_G) + 1;

   // Active-high patterns, {g,f,e,d,c,b,a}; entry 15 leftmost.
   localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   typedef enum logic {
      ST_GUARD = 1'b0,
      ST_ON    = 1'b1
   } scan_state_e;

   function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] hex);
      return SEG_TABLE[hex];
   endfunction

endpackage

// File: rtl/display_mux_driver_seg7_decoder.sv
// Combinational hex -> active-high 7-segment lookup, shared by display blocks.
module seg7_decoder
   import display_mux_driver_pkg::*;
(
   input  logic [3:0]       hex_i,
   output logic [SEG_W-1:0] seg_o
);

   assign seg_o = hex_to_seg(hex_i);

endmodule

// File: rtl/display_mux_driver.sv
// Time-multiplexed common-anode 7-segment driver with per-slot guard interval,
// frame-aligned data updates, per-digit blinking and leading-zero blanking.
module display_mux_driver
   import display_mux_driver_pkg::*;
#(
   parameter int DIGITS_NUM         = 4,
   parameter int SCAN_PRESC_MODULO  = 1000,
   parameter int GUARD_TICKS        = 2,
   parameter int BLINK_FRAMES       = 64,
   parameter int LEADING_ZERO_BLANK = 0,
   parameter int SEG_ACTIVE_LOW     = 1,
   parameter int AN_ACTIVE_LOW      = 1
) (
   input  logic                      CLK,
   input  logic                      CLR_N,
   input  logic                      CE,
   input  logic                      LOAD,
   input  logic [4*DIGITS_NUM-1:0]   BCD_IN,
   input  logic [DIGITS_NUM-1:0]     DP_IN,
   input  logic [DIGITS_NUM-1:0]     BLINK_MASK,
   input  logic                      BLINK_EN,
   output logic [SEG_W-1:0]          SEG,
   output logic                      DP,
   output logic [DIGITS_NUM-1:0]     AN,
   output logic                      FRAME_END
);

   localparam int PW = $clog2(SCAN_PRESC_MODULO);
   localparam int SW = $clog2(DIGITS_NUM);
   localparam int BW = $clog2(BLINK_FRAMES + 1);

   localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_PRESC_MODULO - 1);
   localparam logic [PW-1:0] GUARD_END = PW'(GUARD_TICKS - 1);
   localparam logic [SW-1:0] SLOT_MAX  = SW'(DIGITS_NUM - 1);
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES - 1);

   localparam logic [DIGITS_NUM-1:0] AN_OFF  = {DIGITS_NUM{AN_ACTIVE_LOW != 0}};
   localparam logic [SEG_W-1:0]      SEG_OFF = {SEG_W{SEG_ACTIVE_LOW != 0}};
   localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);

   logic [PW-1:0]             presc_q;
   logic [SW-1:0]             slot_q;
   scan_state_e               state_q;
   logic [BW-1:0]             blink_cnt_q;
   logic                      blink_phase_q;

   logic [4*DIGITS_NUM-1:0]   pend_bcd_q, pend_bcd_d, act_bcd_q;
   logic [DIGITS_NUM-1:0]     pend_dp_q, pend_dp_d, act_dp_q;
   logic [DIGITS_NUM-1:0]     pend_mask_q, pend_mask_d, act_mask_q;

   logic [DIGITS_NUM-1:0]     an_q;
   logic [SEG_W-1:0]          seg_q;
   logic                      dp_q;
   logic                      frame_end_q;

   logic                      presc_last, slot_last, frame_tick;
   logic [3:0]                cur_hex;
   logic [SEG_W-1:0]          cur_seg;
   logic                      cur_dp, cur_mask, suppress;
   logic [DIGITS_NUM-1:0]     lz_blank;
   logic                      all_zero;
   logic [DIGITS_NUM-1:0]     an_sel;

   assign presc_last = (presc_q == PRESC_MAX);
   assign slot_last  = (slot_q == SLOT_MAX);
   assign frame_tick = CE & presc_last & slot_last;

   // A LOAD coinciding with the frame-end tick is forwarded straight to the
   // active register through these next-state values.
   always_comb begin
      pend_bcd_d  = pend_bcd_q;
      pend_dp_d   = pend_dp_q;
      pend_mask_d = pend_mask_q;
      if (LOAD) begin
         pend_bcd_d  = BCD_IN;
         pend_dp_d   = DP_IN;
         pend_mask_d = BLINK_MASK;
      end
   end

   // NOTE: blocking assignments in always_comb; all_zero accumulates from the
   // most-significant digit downwards within a single evaluation.
   always_comb begin
      lz_blank = '0;
      all_zero = 1'b1;
      for (int i = DIGITS_NUM - 1; i >= 1; i--) begin
         all_zero    = all_zero & (act_bcd_q[4*i +: 4] == 4'h0);
         lz_blank[i] = all_zero & (LEADING_ZERO_BLANK != 0);
      end
   end

   assign cur_hex  = act_bcd_q[4*slot_q +: 4];
   assign cur_dp   = act_dp_q[slot_q];
   assign cur_mask = act_mask_q[slot_q];
   assign suppress = lz_blank[slot_q] | (blink_phase_q & BLINK_EN & cur_mask);
   assign an_sel   = DIGITS_NUM'(1) << slot_q;

   seg7_decoder u_seg7_decoder (
      .hex_i (cur_hex),
      .seg_o (cur_seg)
   );

   // NOTE: the small data registers are reset along with the counters so a
   // reset always restarts with a blank (all-zero) frame.
   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         presc_q       <= '0;
         slot_q        <= '0;
         state_q       <= ST_GUARD;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         pend_bcd_q    <= '0;
         pend_dp_q     <= '0;
         pend_mask_q   <= '0;
         act_bcd_q     <= '0;
         act_dp_q      <= '0;
         act_mask_q    <= '0;
         an_q          <= AN_OFF;
         seg_q         <= SEG_OFF;
         dp_q          <= DP_OFF;
         frame_end_q   <= 1'b0;
      end else begin
         // FRAME_END is a pulse; it is not frozen when CE drops.
         frame_end_q <= frame_tick;
         pend_bcd_q  <= pend_bcd_d;
         pend_dp_q   <= pend_dp_d;
         pend_mask_q <= pend_mask_d;

         if (CE) begin
            presc_q <= presc_last ? '0 : presc_q + 1'b1;
            if (presc_last) begin
               slot_q <= slot_last ? '0 : slot_q + 1'b1;
            end

            case (state_q)
               ST_GUARD: if (presc_q == GUARD_END) state_q <= ST_ON;
               ST_ON:    if (presc_last)           state_q <= ST_GUARD;
               default:                            state_q <= ST_GUARD;
            endcase

            if (frame_tick) begin
               act_bcd_q  <= pend_bcd_d;
               act_dp_q   <= pend_dp_d;
               act_mask_q <= pend_mask_d;
               if (blink_cnt_q == BLINK_MAX) begin
                  blink_cnt_q   <= '0;
                  blink_phase_q <= ~blink_phase_q;
               end else begin
                  blink_cnt_q <= blink_cnt_q + 1'b1;
               end
            end

            if (state_q == ST_ON && !suppress) begin
               an_q  <= an_sel ^ AN_OFF;
               seg_q <= cur_seg ^ SEG_OFF;
               dp_q  <= cur_dp ^ DP_OFF;
            end else begin
               an_q  <= AN_OFF;
               seg_q <= SEG_OFF;
               dp_q  <= DP_OFF;
            end
         end
      end
   end

   assign AN        = an_q;
   assign SEG       = seg_q;
   assign DP        = dp_q;
   assign FRAME_END = frame_end_q;

endmodule

// File: tb/tb_display_mux_driver.sv
// Scoreboard bench for display_mux_driver: stimulus queues the expected lit
// digits per frame; monitors pop them whenever a DUT lights a digit or ends a frame.
module tb_display_mux_driver;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       fe;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        CLR_N, rst_lz_n, CE, LOAD, BLINK_EN;
   logic [15:0] BCD_IN;
   logic [3:0]  DP_IN, BLINK_MASK;
   logic [6:0]  SEG, seg_lz;
   logic        DP, dp_lz, FRAME_END, fe_lz;
   logic [3:0]  AN, an_lz;

   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;
   int   fe_cyc;
   logic ce_prev  = 1'b0;
   bit   mon_main = 1'b0;
   bit   mon_lz   = 1'b0;
   exp_t q_main[$];
   exp_t q_lz[$];
   exp_t e_main, e_lz;

   // Active-low patterns for hex 0..F, worked out by hand.
   logic [6:0] exp_seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   display_mux_driver #(
      .DIGITS_NUM(4), .SCAN_PRESC_MODULO(4), .GUARD_TICKS(1), .BLINK_FRAMES(2),
      .LEADING_ZERO_BLANK(0), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
   ) dut (
      .CLK(clk), .CLR_N(CLR_N), .CE(CE), .LOAD(LOAD), .BCD_IN(BCD_IN), .DP_IN(DP_IN),
      .BLINK_MASK(BLINK_MASK), .BLINK_EN(BLINK_EN), .SEG(SEG), .DP(DP), .AN(AN),
      .FRAME_END(FRAME_END)
   );

   display_mux_driver #(
      .DIGITS_NUM(4), .SCAN_PRESC_MODULO(4), .GUARD_TICKS(1), .BLINK_FRAMES(2),
      .LEADING_ZERO_BLANK(1), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
   ) dut_lz (
      .CLK(clk), .CLR_N(rst_lz_n), .CE(CE), .LOAD(LOAD), .BCD_IN(BCD_IN), .DP_IN(DP_IN),
      .BLINK_MASK(BLINK_MASK), .BLINK_EN(BLINK_EN), .SEG(seg_lz), .DP(dp_lz), .AN(an_lz),
      .FRAME_END(fe_lz)
   );

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      ce_prev <= CE;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_frame(input bit lz, input logic [15:0] bcd, input logic [3:0] dp,
                             input logic [3:0] shown);
      exp_t e;
      for (int d = 0; d < 4; d++) begin
         if (shown[d]) begin
            for (int c = 0; c < 3; c++) begin
               e.an  = ~(4'b0001 << d);
               e.seg = exp_seg_tab[bcd[4*d +: 4]];
               e.dp  = ~dp[d];
               e.fe  = (d == 3 && c == 2);
               if (lz) q_lz.push_back(e); else q_main.push_back(e);
            end
         end
      end
      if (!shown[3]) begin
         e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fe: 1'b1};
         if (lz) q_lz.push_back(e); else q_main.push_back(e);
      end
   endtask

   task automatic wait_fe(input bit lz);
      bit seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         seen = lz ? fe_lz : FRAME_END;
      end
      if (!seen) begin
         n_vec++;
         n_err++;
         $display("FAIL wait_fe(lz=%0d): got no FRAME_END, expected one within 100 cycles", lz);
      end
   endtask

   // Monitors: an output event is a lit digit or a frame end after an active CE cycle.
   always @(negedge clk) begin
      if (mon_main && ce_prev && (AN != 4'hF || FRAME_END)) begin
         if (q_main.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_main: got an=%b seg=%h fe=%b, expected no output", AN, SEG, FRAME_END);
         end else begin
            e_main = q_main.pop_front();
            check("sb_main", {AN, SEG, DP, FRAME_END}, e_main);
         end
      end
   end

   always @(negedge clk) begin
      if (mon_lz && ce_prev && (an_lz != 4'hF || fe_lz)) begin
         if (q_lz.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_lz: got an=%b seg=%h fe=%b, expected no output", an_lz, seg_lz, fe_lz);
         end else begin
            e_lz = q_lz.pop_front();
            check("sb_lz", {an_lz, seg_lz, dp_lz, fe_lz}, e_lz);
         end
      end
   end

   initial begin
      CLR_N = 1'b0; rst_lz_n = 1'b0; CE = 1'b1; LOAD = 1'b0; BLINK_EN = 1'b0;
      BCD_IN = '0; DP_IN = '0; BLINK_MASK = '0;
      repeat (3) @(negedge clk);
      check("rst_an", AN, 4'hF);
      check("rst_seg", SEG, 7'h7F);
      check("rst_dp", DP, 1'b1);
      check("rst_fe", FRAME_END, 1'b0);

      // Frame 0 after release shows the reset data (all zero).
      push_frame(0, 16'h0000, 4'h0, 4'hF);
      CLR_N = 1'b1;
      mon_main = 1'b1;
      @(negedge clk); check("rel_guard", AN, 4'hF);
      @(negedge clk); check("rel_first_an", {AN, SEG}, {4'b1110, 7'h40});

      // Basic scan: 1230 with DP on digit 2, shown in frames 1 and 2.
      push_frame(0, 16'h1230, 4'b0100, 4'hF);
      push_frame(0, 16'h1230, 4'b0100, 4'hF);
      LOAD = 1'b1; BCD_IN = 16'h1230; DP_IN = 4'b0100;
      @(negedge clk); LOAD = 1'b0;
      wait_fe(0);
      fe_cyc = cyc;
      @(negedge clk); check("slot0_guard", AN, 4'hF);
      @(negedge clk); check("slot0_on", {AN, SEG, DP}, {4'b1110, 7'h40, 1'b1});
      repeat (2) @(negedge clk); check("slot0_on_last", AN, 4'b1110);
      @(negedge clk); check("slot1_guard", AN, 4'hF);
      wait_fe(0);
      check("fe_period", cyc - fe_cyc, 16);

      // Tear-free: mid-frame load only shows from the next frame.
      push_frame(0, 16'h8888, 4'h0, 4'hF);
      repeat (5) @(negedge clk);
      LOAD = 1'b1; BCD_IN = 16'h8888; DP_IN = 4'h0;
      @(negedge clk); LOAD = 1'b0;
      wait_fe(0);
      // Load on the frame-end tick itself is transferred at that boundary.
      push_frame(0, 16'h4567, 4'h0, 4'hF);
      repeat (15) @(negedge clk);
      LOAD = 1'b1; BCD_IN = 16'h4567;
      @(negedge clk); LOAD = 1'b0;
      check("fe_on_bypass_tick", FRAME_END, 1'b1);

      // Blink on digit 0: last of two loads wins; phase is 1 in frames 6,7.
      push_frame(0, 16'h9BCF, 4'b1001, 4'hF);
      push_frame(0, 16'h9BCF, 4'b1001, 4'hE);
      push_frame(0, 16'h9BCF, 4'b1001, 4'hE);
      push_frame(0, 16'h9BCF, 4'b1001, 4'hF);
      push_frame(0, 16'h9BCF, 4'b1001, 4'hF);
      repeat (3) @(negedge clk);
      LOAD = 1'b1; BCD_IN = 16'hAAAA; DP_IN = 4'h0; BLINK_MASK = 4'h0;
      @(negedge clk);
      BCD_IN = 16'h9BCF; DP_IN = 4'b1001; BLINK_MASK = 4'b0001; BLINK_EN = 1'b1;
      @(negedge clk); LOAD = 1'b0;
      repeat (5) wait_fe(0);
      // Blink disabled: frames 10,11 (phase 1) still show digit 0.
      BLINK_EN = 1'b0;
      push_frame(0, 16'h9BCF, 4'b1001, 4'hF);
      push_frame(0, 16'h9BCF, 4'b1001, 4'hF);
      push_frame(0, 16'h9BCF, 4'b1001, 4'hF);
      repeat (3) wait_fe(0);

      // CE gating inside slot 1 of frame 12.
      repeat (6) @(negedge clk);
      check("pre_freeze", {AN, SEG, FRAME_END}, {4'b1101, 7'h46, 1'b0});
      CE = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("ce_hold", {AN, SEG, DP, FRAME_END}, {4'b1101, 7'h46, 1'b1, 1'b0});
      end
      CE = 1'b1;
      repeat (9) @(negedge clk);
      check("resume_no_fe", FRAME_END, 1'b0);
      @(negedge clk);
      check("resume_fe", FRAME_END, 1'b1);
      @(negedge clk);
      mon_main = 1'b0;
      check("sb_main_drained", q_main.size(), 0);

      // Leading-zero blanking instance: 0000, then 0050, then 0402.
      push_frame(1, 16'h0000, 4'h0, 4'b0001);
      push_frame(1, 16'h0050, 4'b1101, 4'b0011);
      push_frame(1, 16'h0402, 4'h0, 4'b0111);
      LOAD = 1'b1; BCD_IN = 16'h0050; DP_IN = 4'b1101; BLINK_MASK = 4'h0;
      rst_lz_n = 1'b1;
      mon_lz = 1'b1;
      @(negedge clk); LOAD = 1'b0;
      wait_fe(1);
      repeat (3) @(negedge clk);
      LOAD = 1'b1; BCD_IN = 16'h0402; DP_IN = 4'h0;
      @(negedge clk); LOAD = 1'b0;
      wait_fe(1);
      wait_fe(1);
      @(negedge clk);
      mon_lz = 1'b0;
      check("sb_lz_drained", q_lz.size(), 0);

      // Asynchronous reset mid-scan while digit 0 (value 2) is lit.
      wait_fe(0);
      repeat (2) @(negedge clk);
      check("pre_reset_lit", {AN, SEG}, {4'b1110, 7'h24});
      #2 CLR_N = 1'b0;
      #1;
      check("async_rst_an", AN, 4'hF);
      check("async_rst_seg", SEG, 7'h7F);
      check("async_rst_dp", DP, 1'b1);
      check("async_rst_fe", FRAME_END, 1'b0);
      repeat (5) @(negedge clk);
      check("rst_hold", {AN, SEG, DP, FRAME_END}, {4'hF, 7'h7F, 1'b1, 1'b0});
      CLR_N = 1'b1;
      @(negedge clk); check("rerel_guard", AN, 4'hF);
      @(negedge clk); check("rerel_zero_data", {AN, SEG}, {4'b1110, 7'h40});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/display_mux_driver.md
Name: display_mux_driver

Overview:
- Output-side counterpart of the switch debouncer: where the debouncer turns a physical key into clean key events, this block drives the multiplexed common-anode 7-segment display of the countdown timer.
- Scans DIGITS_NUM digits in time-multiplexed slots, with a per-slot guard interval against ghosting.
- Supports per-digit blinking, optional leading-zero blanking and tear-free data updates aligned to frame boundaries.

Parameters:
DIGITS_NUM, 4, number of digits scanned (>=2)
SCAN_PRESC_MODULO, 1000, CE ticks per digit slot (>=2)
GUARD_TICKS, 2, CE ticks at the start of each slot with all anodes inactive (1..SCAN_PRESC_MODULO-1)
BLINK_FRAMES, 64, frames per blink half-period (>=1)
LEADING_ZERO_BLANK, 0, 1 = blank most-significant zero digits; digit 0 is never blanked
SEG_ACTIVE_LOW, 1, segment/DP outputs active-low
AN_ACTIVE_LOW, 1, anode outputs active-low

Ports:
CLK  in  1  system clock
CLR_N  in  1  asynchronous active-low reset
CE  in  1  scan clock enable; all counters advance only when high
LOAD  in  1  one-cycle strobe that captures BCD_IN/DP_IN/BLINK_MASK into the pending register
BCD_IN  in  4*DIGITS_NUM  hex digit codes; digit i = BCD_IN[4i+3:4i], digit 0 least significant
DP_IN  in  DIGITS_NUM  decimal point per digit
BLINK_MASK  in  DIGITS_NUM  digits subject to blinking
BLINK_EN  in  1  global blink enable (not registered)
SEG  out  7  {g,f,e,d,c,b,a}
DP  out  1  decimal point
AN  out  DIGITS_NUM  anode select, AN[i] = digit i
FRAME_END  out  1  one-CLK pulse marking the last CE tick of each frame

Behaviour:
- Single clock CLK. Reset is asynchronous, active-low, on CLR_N; all state is cleared while CLR_N=0.
- Reset values:
  - AN all inactive; SEG and DP off (polarity per parameters); FRAME_END=0.
  - Slot index 0; prescaler 0; FSM in GUARD; blink counter 0; blink phase 0 (visible).
  - Pending and active registers all zero.
- Prescaler counts CE ticks 0..SCAN_PRESC_MODULO-1 within a slot, then wraps; the slot index advances 0..DIGITS_NUM-1 and wraps.
- FSM, per slot:
  - GUARD: entered at slot start. AN all inactive, SEG/DP off. Moves to ON when prescaler = GUARD_TICKS-1 and CE=1.
  - ON: AN[slot] active; SEG/DP show the decoded active digit. Moves to GUARD at the slot wrap.
- CE=0: all state and outputs hold.
- Outputs are registered: they reflect the counter/FSM state with 1-CLK latency.
- Decode, full hex 0-F, standard patterns. With active-low segments: 0->7'h40, 1->7'h79, 2->7'h24, 3->7'h30, 5->7'h12, 8->7'h00, F->7'h0E.
- Data path:
  - LOAD writes the pending register.
  - On the frame-end tick (CE=1, slot=DIGITS_NUM-1, prescaler=max), pending is copied to active.
  - LOAD on that same cycle: the newly loaded value is the one transferred (bypass).
  - Multiple LOADs within one frame: last one wins.
- FRAME_END is high for the single CLK cycle following the frame-end tick, aligned with the registered outputs.
- Blink:
  - Blink counter increments on each frame end; at BLINK_FRAMES-1 it wraps and toggles the blink phase.
  - While phase=1, BLINK_EN=1 and the mask bit of the current digit is set, the digit is suppressed: AN inactive, SEG/DP off for the whole slot.
- Leading-zero blanking (LEADING_ZERO_BLANK=1):
  - Digit i is blanked if it and all higher digits are zero, for i>=1.
  - Blanked digits behave like blink-suppressed digits; their DP is also suppressed.
- Reset mid-frame: outputs go inactive immediately; after release, scanning restarts at slot 0 in GUARD with active data = 0.

Decomposition:
- Shared package/include holds:
  - the 16-entry segment decode constant table (active-high form; inversion done in this block);
  - the segment bit-order constants;
  - the FSM state encoding (GUARD=1'b0, ON=1'b1).
- One sub-module, seg7_decoder: combinational hex->segment lookup, reused by other display-related blocks.
- The counters stay inline, in the same style as DOWN_CNT.

Test Plan:
- Config for all tests unless noted: DIGITS_NUM=4, SCAN_PRESC_MODULO=4, GUARD_TICKS=1, BLINK_FRAMES=2, CE tied high, active-low outputs.
- Reset: hold CLR_N=0 for 5 cycles mid-scan -> AN=4'hF, SEG=7'h7F, DP=1, FRAME_END=0 asynchronously. Release -> first anode 4'b1110 appears 2 cycles later.
- Basic scan: LOAD BCD_IN=16'h1230. After the next frame end:
  - slot AN=1110 shows SEG=7'h40; AN=1101 shows 7'h30; AN=1011 shows 7'h24; AN=0111 shows 7'h79;
  - each slot is 1 guard cycle with AN=F, then 3 ON cycles;
  - FRAME_END pulses every 16 cycles.
- Tear-free update: LOAD 16'h8888 mid-frame -> the current frame still shows 1230; the next frame shows SEG=7'h00 on all digits. A LOAD on the frame-end cycle takes effect at that boundary.
- Blink: BLINK_MASK=4'b0001, BLINK_EN=1 -> AN[0] never active for 2 frames, then active for 2 frames, repeating. BLINK_EN=0 -> always active.
- Leading-zero blanking (LEADING_ZERO_BLANK=1): BCD_IN=16'h0050 -> AN[3] and AN[2] never active; digit1 SEG=7'h12; digit0 SEG=7'h40. BCD_IN=0 -> only digit0 shown.
- CE gating: CE=0 for 20 cycles mid-slot -> AN/SEG frozen, FRAME_END never asserted; scanning resumes from the same point.
